// File: rtl/abft_pkg.sv
// Shared types, sizes and width helpers for the ABFT 4x4 matrix-multiply controller.
package abft_pkg;

   localparam int N = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      CHECK,
      DRAIN
   } state_t;

   // Z element width: four DW x DW products summed.
   function automatic int zw_of(input int dw);
      return 2 * dw + 2;
   endfunction

   // Checksum width: sum of 16 Z elements, or 4 products of (DW+2)-bit line sums.
   function automatic int cw_of(input int dw);
      return 2 * dw + 6;
   endfunction

   // MAC operand width: wide enough for a column/row sum of four elements.
   function automatic int aw_of(input int dw);
      return dw + 2;
   endfunction

endpackage

// File: rtl/abft_mac.sv
// Registered multiply-accumulate shared by the Z computation and the input checksum.
// 'first' starts a new sum from the current product; 'nxt' exposes the value being registered.
module abft_mac #(
   parameter int AW = 10,
   parameter int OW = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          first,
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   output logic [OW-1:0] acc,
   output logic [OW-1:0] nxt
);

   assign nxt = (first ? '0 : acc) + (OW'(a) * OW'(b));

   // Accumulator register: cleared on reset/clr, updated when enabled.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= nxt;
      end
   end

endmodule

// File: rtl/abft_mm_ctrl.sv
// Sequential ABFT 4x4 matrix multiplier: load X/Y, compute Z on one MAC,
// verify sum(Z) against sum_k colsum(X)[k]*rowsum(Y)[k], retry on mismatch, stream Z out.
module abft_mm_ctrl
   import abft_pkg::*;
#(
   parameter int  DW        = 8,
   parameter int  MAX_RETRY = 1,
   localparam int ZW        = zw_of(DW),
   localparam int CW        = cw_of(DW),
   localparam int AW        = aw_of(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          inj_en,
   input  logic [3:0]    inj_idx,
   input  logic [ZW-1:0] inj_mask,
   output logic [ZW-1:0] z_data,
   output logic          z_valid,
   input  logic          z_ready,
   output logic          z_last,
   output logic          busy,
   output logic          done,
   output logic          fault,
   output logic          retried
);

   state_t        state, state_n;
   logic [5:0]    cnt;
   logic [DW-1:0] x_mem [N*N];
   logic [DW-1:0] y_mem [N*N];
   logic [ZW-1:0] z_mem [N*N];
   logic [AW-1:0] colsum [N];
   logic [AW-1:0] rowsum [N];
   logic [CW-1:0] cs_out;
   logic [7:0]    attempt;
   logic          inj_en_q;
   logic [3:0]    inj_idx_q;
   logic [ZW-1:0] inj_mask_q;
   logic          mac_clr, mac_en, mac_first;
   logic [AW-1:0] mac_a, mac_b;
   logic [CW-1:0] mac_acc, mac_nxt;
   logic [ZW-1:0] z_val;
   logic          accept, z_hs, cs_match, can_retry, inj_hit;

   assign accept    = (state == LOAD) && in_valid;
   assign z_hs      = (state == DRAIN) && z_ready;
   assign cs_match  = (mac_acc == cs_out);
   assign can_retry = (attempt < 8'(MAX_RETRY));
   assign inj_hit   = inj_en_q && (attempt == 8'd0) && (cnt[5:2] == inj_idx_q);
   assign z_val     = mac_nxt[ZW-1:0] ^ (inj_hit ? inj_mask_q : '0);
   assign z_data    = z_mem[cnt[3:0]];

   abft_mac #(.AW(AW), .OW(CW)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr   (mac_clr),
      .en    (mac_en),
      .first (mac_first),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (mac_acc),
      .nxt   (mac_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state, handshake outputs and MAC operand selection.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      z_valid   = 1'b0;
      z_last    = 1'b0;
      busy      = (state != IDLE);
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      mac_first = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      case (state)
         IDLE: begin
            mac_clr = 1'b1;
            if (start) state_n = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 6'd31) state_n = COMPUTE;
         end
         COMPUTE: begin
            // cnt = {i, j, k}: X[i][k] * Y[k][j]
            mac_en    = 1'b1;
            mac_first = (cnt[1:0] == 2'd0);
            mac_a     = AW'(x_mem[{cnt[5:4], cnt[1:0]}]);
            mac_b     = AW'(y_mem[{cnt[1:0], cnt[3:2]}]);
            if (cnt == 6'd63) state_n = CHECK;
         end
         CHECK: begin
            if (cnt < 6'd4) begin
               mac_en    = 1'b1;
               mac_first = (cnt == 6'd0);
               mac_a     = colsum[cnt[1:0]];
               mac_b     = rowsum[cnt[1:0]];
            end else begin
               mac_clr = 1'b1;
               if (!cs_match && can_retry) state_n = COMPUTE;
               else                        state_n = DRAIN;
            end
         end
         DRAIN: begin
            z_valid = 1'b1;
            z_last  = (cnt[3:0] == 4'd15);
            if (z_ready && cnt[3:0] == 4'd15) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Control: counters, line sums, output checksum, retry and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         cs_out     <= '0;
         attempt    <= '0;
         done       <= 1'b0;
         fault      <= 1'b0;
         retried    <= 1'b0;
         inj_en_q   <= 1'b0;
         inj_idx_q  <= '0;
         inj_mask_q <= '0;
         for (int n = 0; n < N; n++) begin
            colsum[n] <= '0;
            rowsum[n] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt        <= '0;
                  cs_out     <= '0;
                  attempt    <= '0;
                  fault      <= 1'b0;
                  retried    <= 1'b0;
                  inj_en_q   <= inj_en;
                  inj_idx_q  <= inj_idx;
                  inj_mask_q <= inj_mask;
                  for (int n = 0; n < N; n++) begin
                     colsum[n] <= '0;
                     rowsum[n] <= '0;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
                  if (!cnt[4]) colsum[cnt[1:0]] <= colsum[cnt[1:0]] + AW'(in_data);
                  else         rowsum[cnt[3:2]] <= rowsum[cnt[3:2]] + AW'(in_data);
               end
            end
            COMPUTE: begin
               cnt <= cnt + 6'd1;
               if (cnt[1:0] == 2'd3) cs_out <= cs_out + CW'(z_val);
            end
            CHECK: begin
               if (cnt == 6'd4) begin
                  cnt <= '0;
                  if (!cs_match && can_retry) begin
                     attempt <= attempt + 8'd1;
                     retried <= 1'b1;
                     cs_out  <= '0;
                  end else begin
                     fault <= !cs_match;
                  end
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            DRAIN: begin
               if (z_hs) begin
                  cnt <= (cnt[3:0] == 4'd15) ? 6'd0 : cnt + 6'd1;
                  if (cnt[3:0] == 4'd15) done <= 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   // Element storage: X/Y written while loading, Z written at the end of each dot product.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (!cnt[4]) x_mem[cnt[3:0]] <= in_data;
         else         y_mem[cnt[3:0]] <= in_data;
      end
      if (state == COMPUTE && cnt[1:0] == 2'd3) z_mem[cnt[5:2]] <= z_val;
   end

endmodule

// File: tb/tb_abft_mm_ctrl.sv
// Directed bench for abft_mm_ctrl: two instances (one retry allowed / no retries).
module tb_abft_mm_ctrl;
   import abft_pkg::*;

   localparam int DW = 8;
   localparam int ZW = zw_of(DW);

   logic          clk = 1'b0;
   logic          rst, start0, start1, in_valid, inj_en, z_ready;
   logic [DW-1:0] in_data;
   logic [3:0]    inj_idx;
   logic [ZW-1:0] inj_mask;

   logic          in_ready0, z_valid0, z_last0, busy0, done0, fault0, retried0;
   logic          in_ready1, z_valid1, z_last1, busy1, done1, fault1, retried1;
   logic [ZW-1:0] z_data0, z_data1;

   logic          sel;
   logic          rdy, zv, zl, bsy, dn, flt, rtr;
   logic [ZW-1:0] zd;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] x_in  [16];
   logic [DW-1:0] y_in  [16];
   logic [ZW-1:0] exp_z [16];

   always #5 clk = ~clk;

   abft_mm_ctrl #(.DW(DW), .MAX_RETRY(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .inj_en(inj_en), .inj_idx(inj_idx), .inj_mask(inj_mask),
      .z_data(z_data0), .z_valid(z_valid0), .z_ready(z_ready), .z_last(z_last0),
      .busy(busy0), .done(done0), .fault(fault0), .retried(retried0)
   );

   abft_mm_ctrl #(.DW(DW), .MAX_RETRY(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .inj_en(inj_en), .inj_idx(inj_idx), .inj_mask(inj_mask),
      .z_data(z_data1), .z_valid(z_valid1), .z_ready(z_ready), .z_last(z_last1),
      .busy(busy1), .done(done1), .fault(fault1), .retried(retried1)
   );

   assign rdy = sel ? in_ready1 : in_ready0;
   assign zv  = sel ? z_valid1  : z_valid0;
   assign zl  = sel ? z_last1   : z_last0;
   assign zd  = sel ? z_data1   : z_data0;
   assign bsy = sel ? busy1     : busy0;
   assign dn  = sel ? done1     : done0;
   assign flt = sel ? fault1    : fault0;
   assign rtr = sel ? retried1  : retried0;

   task automatic set_case1;
      x_in  = '{5, 10, 15, 20, 2, 4, 6, 8, 4, 8, 12, 16, 3, 6, 9, 12};
      y_in  = '{1, 2, 3, 4, 2, 3, 4, 5, 3, 4, 5, 6, 4, 5, 6, 7};
      exp_z = '{150, 200, 250, 300, 60, 80, 100, 120, 120, 160, 200, 240, 90, 120, 150, 180};
   endtask

   task automatic pulse_start(input logic en, input logic [3:0] idx, input logic [ZW-1:0] mask);
      @(negedge clk);
      inj_en = en; inj_idx = idx; inj_mask = mask;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      inj_en = 1'b0; inj_idx = '0; inj_mask = '0;
      tests++;
      if (bsy !== 1'b1 || rdy !== 1'b1) begin
         fails++; $display("FAIL start_to_load: busy=%0b in_ready=%0b want 1/1", bsy, rdy);
      end
   endtask

   // Leaves the bench at the negedge right after the 32nd accepting edge.
   task automatic load_job(input bit gaps);
      int n;
      for (int b = 0; b < 32; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0; @(negedge clk);
            end
         end
         in_data  = (b < 16) ? x_in[b] : y_in[b-16];
         in_valid = 1'b1;
         n = 0;
         while (!rdy && n < 100) begin @(negedge clk); n++; end
         if (!rdy) begin
            tests++; fails++; $display("FAIL load_ready beat %0d: in_ready=0 want 1", b);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain_check(input string nm, input bit stall, input logic exp_fault,
                              input logic exp_retried);
      int n;
      bit bad;
      logic [ZW-1:0] hold;
      n = 0;
      while (!zv && n < 400) begin @(negedge clk); n++; end
      tests++;
      if (!zv) begin
         fails++; $display("FAIL %s_timeout: z_valid=0 after %0d cycles want 1", nm, n);
      end
      tests++;
      if (rdy !== 1'b0) begin
         fails++; $display("FAIL %s_ready_drain: in_ready=%0b want 0", nm, rdy);
      end
      for (int b = 0; b < 16; b++) begin
         if (stall && b == 7) begin
            z_ready = 1'b0; hold = zd; bad = 0;
            repeat (10) begin
               @(negedge clk);
               if (zd !== hold || zv !== 1'b1 || zl !== 1'b0) bad = 1;
            end
            tests++;
            if (bad) begin
               fails++; $display("FAIL %s_stall_stable: z_data=%0d want %0d", nm, zd, hold);
            end
            z_ready = 1'b1;
         end
         tests++;
         if (zd !== exp_z[b] || zl !== (b == 15) || zv !== 1'b1) begin
            fails++;
            $display("FAIL %s_z[%0d]: got %0d last=%0b valid=%0b want %0d last=%0b", nm, b, zd,
                     zl, zv, exp_z[b], (b == 15));
         end
         @(negedge clk);
      end
      tests++;
      if (dn !== 1'b1 || flt !== exp_fault || rtr !== exp_retried || bsy !== 1'b0) begin
         fails++;
         $display("FAIL %s_done: done=%0b fault=%0b retried=%0b busy=%0b want 1/%0b/%0b/0", nm,
                  dn, flt, rtr, bsy, exp_fault, exp_retried);
      end
      @(negedge clk);
      tests++;
      if (dn !== 1'b0 || flt !== exp_fault || rtr !== exp_retried) begin
         fails++;
         $display("FAIL %s_after_done: done=%0b fault=%0b retried=%0b want 0/%0b/%0b", nm, dn,
                  flt, rtr, exp_fault, exp_retried);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_data = '0;
      inj_en = 1'b0; inj_idx = '0; inj_mask = '0; z_ready = 1'b1; sel = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({in_ready0, z_valid0, z_last0, busy0, done0, fault0, retried0} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs0: got %b want 0000000",
                  {in_ready0, z_valid0, z_last0, busy0, done0, fault0, retried0});
      end
      tests++;
      if ({in_ready1, z_valid1, z_last1, busy1, done1, fault1, retried1} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs1: got %b want 0000000",
                  {in_ready1, z_valid1, z_last1, busy1, done1, fault1, retried1});
      end
      // rst wins over a simultaneous start
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; rst = 1'b0;
      @(negedge clk);
      tests++;
      if (busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
         fails++; $display("FAIL reset_priority: busy=%0b in_ready=%0b want 0/0", busy0, in_ready0);
      end
   endtask

   task automatic test_basic;
      int lat;
      sel = 1'b0; set_case1;
      pulse_start(1'b0, 4'd0, '0);
      load_job(0);
      lat = 0;
      while (!zv && lat < 200) begin @(negedge clk); lat++; end
      tests++;
      if (lat != 69) begin
         fails++; $display("FAIL basic_latency: got %0d cycles want 69", lat);
      end
      drain_check("basic", 0, 1'b0, 1'b0);
   endtask

   task automatic test_retry;
      sel = 1'b0; set_case1;
      pulse_start(1'b1, 4'd5, 18'd70);
      load_job(0);
      drain_check("retry", 0, 1'b0, 1'b1);
   endtask

   task automatic test_no_retry;
      sel = 1'b1; set_case1;
      exp_z[5] = 18'd22;
      pulse_start(1'b1, 4'd5, 18'd70);
      load_job(0);
      drain_check("noretry", 0, 1'b1, 1'b0);
      sel = 1'b0;
   endtask

   task automatic test_max_values;
      sel = 1'b0;
      for (int i = 0; i < 16; i++) begin
         x_in[i] = 8'd255; y_in[i] = 8'd255; exp_z[i] = 18'd260100;
      end
      pulse_start(1'b0, 4'd0, '0);
      load_job(0);
      drain_check("maxval", 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_pressure;
      sel = 1'b0; set_case1;
      pulse_start(1'b0, 4'd0, '0);
      load_job(1);
      drain_check("backpr", 1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midjob;
      sel = 1'b0; set_case1;
      pulse_start(1'b0, 4'd0, '0);
      load_job(0);
      repeat (10) @(negedge clk);
      tests++;
      if (busy0 !== 1'b1) begin
         fails++; $display("FAIL midjob_busy: busy=%0b want 1", busy0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (busy0 !== 1'b0 || z_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
         fails++;
         $display("FAIL midjob_abort: busy=%0b z_valid=%0b in_ready=%0b want 0/0/0", busy0,
                  z_valid0, in_ready0);
      end
      pulse_start(1'b0, 4'd0, '0);
      load_job(0);
      repeat (5) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      tests++;
      if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
         fails++; $display("FAIL busy_start: busy=%0b in_ready=%0b want 1/0", busy0, in_ready0);
      end
      drain_check("midjob", 0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_retry;
      test_no_retry;
      test_max_values;
      test_back_pressure;
      test_reset_midjob;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
